if_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the instruction decoder.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel. Accepts in-order responses.
- Presents a registered instruction, its PC and a valid bit to ID.
- Honours stall from the hazard unit and redirect/flush from EX (branch/jump).

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/if_fetch_stage_if_id_reg.sv | 48 ++++
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide types and constants used by the fetch stage and the decoder.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] inst_t;
    typedef logic [XLEN-1:0] addr_t;

    // addi x0,x0,0 -- the canonical bubble presented to decode
    localparam inst_t NOP_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } fetch_state_e;

    function automatic addr_t align_word(input addr_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall freezes, otherwise load or bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter inst_t NOP_INST = NOP_ENC
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  stall,
    input  logic  load,
    input  addr_t load_pc,
    input  inst_t load_inst,
    output logic  id_valid,
    output addr_t id_pc,
    output inst_t id_inst
);

    logic  valid_r;
    addr_t pc_r;
    inst_t inst_r;

    // Pipeline register update; a bubble keeps the last PC so ID sees a stable value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            pc_r    <= 32'h0000_0000;
            inst_r  <= NOP_INST;
        end else if (flush) begin
            valid_r <= 1'b0;
            inst_r  <= NOP_INST;
        end else if (!stall) begin
            if (load) begin
                valid_r <= 1'b1;
                pc_r    <= load_pc;
                inst_r  <= load_inst;
            end else begin
                valid_r <= 1'b0;
                inst_r  <= NOP_INST;
            end
        end
    end

    assign id_valid = valid_r;
    assign id_pc    = pc_r;
    assign id_inst  = inst_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one request in flight, and feeds the IF/ID register.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter inst_t NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    fetch_state_e state_r;
    addr_t        pc_r;
    addr_t        req_pc_r;
    inst_t        hold_inst_r;

    logic         req_valid_s;
    logic         req_fire_s;
    logic         load_s;
    inst_t        load_inst_s;

    // Request is only offered when nothing else is outstanding (or the reply is retiring now)
    always_comb begin
        req_valid_s = 1'b0;
        case (state_r)
            REQ:     req_valid_s = !redirect_i;
            WAIT:    req_valid_s = imem_resp_valid_i && !stall_i && !redirect_i;
            default: req_valid_s = 1'b0;
        endcase
    end

    assign imem_req_valid_o = req_valid_s && !rst;
    assign imem_req_addr_o  = pc_r;
    assign req_fire_s       = req_valid_s && imem_req_ready_i;

    // Select what, if anything, enters IF/ID this cycle
    always_comb begin
        load_s      = 1'b0;
        load_inst_s = hold_inst_r;
        if (state_r == WAIT && imem_resp_valid_i && !stall_i) begin
            load_s      = 1'b1;
            load_inst_s = imem_resp_data_i;
        end else if (state_r == HOLD && !stall_i) begin
            load_s      = 1'b1;
            load_inst_s = hold_inst_r;
        end else begin
            load_s      = 1'b0;
        end
    end

    // Fetch FSM, PC and hold buffer; redirect overrides everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= REQ;
            pc_r        <= RESET_PC;
            req_pc_r    <= RESET_PC;
            hold_inst_r <= NOP_INST;
        end else if (redirect_i) begin
            pc_r        <= align_word(redirect_pc_i);
            hold_inst_r <= NOP_INST;
            case (state_r)
                WAIT:    state_r <= imem_resp_valid_i ? REQ : KILL;
                KILL:    state_r <= imem_resp_valid_i ? REQ : KILL;
                default: state_r <= REQ;
            endcase
        end else begin
            case (state_r)
                REQ: begin
                    if (req_fire_s) begin
                        req_pc_r <= pc_r;
                        pc_r     <= pc_r + 32'd4;
                        state_r  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid_i) begin
                        if (stall_i) begin
                            hold_inst_r <= imem_resp_data_i;
                            state_r     <= HOLD;
                        end else if (req_fire_s) begin
                            req_pc_r <= pc_r;
                            pc_r     <= pc_r + 32'd4;
                            state_r  <= WAIT;
                        end else begin
                            state_r <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        state_r <= REQ;
                    end
                end
                KILL: begin
                    if (imem_resp_valid_i) begin
                        state_r <= REQ;
                    end
                end
                default: state_r <= REQ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .stall     (stall_i),
        .load      (load_s),
        .load_pc   (req_pc_r),
        .load_inst (load_inst_s),
        .id_valid  (id_valid_o),
        .id_pc     (id_pc_o),
        .id_inst   (id_inst_o)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: cycle-by-cycle stimulus with hand-computed expectations.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int vectors;
    int miscompares;

    if_fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .id_valid_o        (id_valid_o),
        .id_pc_o           (id_pc_o),
        .id_inst_o         (id_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs away from the clock edge, then let combinational outputs settle
    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic rv, input logic [31:0] rdata);
        stall_i           = st;
        redirect_i        = rd;
        redirect_pc_i     = rpc;
        imem_req_ready_i  = rdy;
        imem_resp_valid_i = rv;
        imem_resp_data_i  = rdata;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, id_valid_o}, {31'd0, v});
        chk({tag, "_pc"}, id_pc_o, pc);
        chk({tag, "_inst"}, id_inst_o, inst);
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
        chk({tag, "_rvalid"}, {31'd0, imem_req_valid_o}, {31'd0, v});
        if (v) chk({tag, "_addr"}, imem_req_addr_o, addr);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

        // Reset state, request forced low even with ready high
        repeat (2) tick();
        chk_req("rst", 1'b0, 32'd0);
        chk_id("rst", 1'b0, 32'h0, 32'h0000_0013);
        rst = 1'b0;

        // Back-to-back fetch with a 1-cycle memory
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("f0", 1'b1, 32'h0);
        tick();
        chk_id("f0", 1'b0, 32'h0, 32'h0000_0013);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0000);
        chk_req("f1", 1'b1, 32'h4);
        tick();
        chk_id("f1", 1'b1, 32'h0, 32'hA000_0000);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0004);
        chk_req("f2", 1'b1, 32'h8);
        tick();
        chk_id("f2", 1'b1, 32'h4, 32'hA000_0004);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0008);
        chk_req("f3", 1'b1, 32'hC);
        tick();
        chk_id("f3", 1'b1, 32'h8, 32'hA000_0008);

        // Response for 0xC arrives under a 3-cycle stall
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0050_0093);
        chk_req("st0", 1'b0, 32'd0);
        tick();
        chk_id("st0", 1'b1, 32'h8, 32'hA000_0008);
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("st1", 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("st2", 1'b0, 32'd0);
        tick();
        chk_id("st2", 1'b1, 32'h8, 32'hA000_0008);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("rel", 1'b0, 32'd0);
        tick();
        chk_id("rel", 1'b1, 32'hC, 32'h0050_0093);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("after_hold", 1'b1, 32'h10);
        tick();
        chk_id("after_hold", 1'b0, 32'hC, 32'h0000_0013);

        // Redirect while waiting on a slow response; the stale reply must vanish
        drive(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'd0);
        chk_req("redir", 1'b0, 32'd0);
        tick();
        chk_id("redir", 1'b0, 32'hC, 32'h0000_0013);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("kill0", 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk_req("kill1", 1'b0, 32'd0);
        tick();
        chk_id("stale", 1'b0, 32'hC, 32'h0000_0013);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("tgt", 1'b1, 32'h100);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_0100);
        chk_req("tgt_resp", 1'b1, 32'h104);
        tick();
        chk_id("tgt", 1'b1, 32'h100, 32'hA000_0100);

        // Redirect together with stall and a response: flush wins
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("pre_flush", 1'b1, 32'h104);
        tick();
        chk_id("pre_flush", 1'b1, 32'h100, 32'hA000_0100);
        drive(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h1111_1111);
        chk_req("flush", 1'b0, 32'd0);
        tick();
        chk_id("flush", 1'b0, 32'h100, 32'h0000_0013);

        // Ready held low for 5 cycles: stable request, bubbles to ID
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            chk_req("noready", 1'b1, 32'h200);
            tick();
            chk("noready_idv", {31'd0, id_valid_o}, 32'd0);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("ready", 1'b1, 32'h200);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_0200);
        chk_req("ready_resp", 1'b1, 32'h204);
        tick();
        chk_id("ready", 1'b1, 32'h200, 32'hA000_0200);

        // Asynchronous reset in the middle of a WAIT
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        tick();
        chk_id("pre_rst", 1'b1, 32'h200, 32'hA000_0200);
        #2;
        rst = 1'b1;
        #1;
        chk_id("async_rst", 1'b0, 32'h0, 32'h0000_0013);
        chk_req("async_rst", 1'b0, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
        chk_req("post_rst", 1'b1, 32'h0);
        tick();
        chk_id("late_resp", 1'b0, 32'h0, 32'h0000_0013);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_req("post_rst2", 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_0000);
        tick();
        chk_id("post_rst", 1'b1, 32'h0, 32'hA000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
